csa_accum_ctrl: RTL

//  Sequencer that sums a burst of N 13-bit operands through one carry-save adder (csa) stage.

---
 rtl/csa_accum_ctrl_if.sv | 26 ++
 rtl/csa_accum_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl_if.sv
// Operand-stream and result handshake bundle for csa_accum_ctrl.
// The master side issues bursts and consumes results; the slave side is the accumulator.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 13,
    parameter int CNT_W = 5
);
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             busy;

    modport master (
        output start, n_terms, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, n_terms, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Burst accumulator: sums up to MAX_TERMS operands in redundant sum/carry form through a
// single carry-save stage, then resolves with one carry-propagate add and hands the result out.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start; n_terms sampled here
// ST_ACCUM   | accepting operands, one csa pass per transfer
// ST_RESOLVE | single cycle carry-propagate add of sum and shifted carry
// ST_OUT     | result presented until the consumer takes it
module csa_accum_ctrl #(
    parameter int MAX_TERMS = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    csa_accum_ctrl_if.slave io_bus
);
    localparam int WIDTH = 13;
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RESOLVE,
        ST_OUT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_carry_sh;
    logic [WIDTH-1:0] w_csa_sum;
    logic [WIDTH-1:0] w_csa_carry;
    logic [CNT_W-1:0] w_terms;
    logic             w_xfer;

    // carry[i] weighs 2^(i+1); the top carry bit falls off the mod-2^WIDTH ring
    assign w_carry_sh  = {r_carry[WIDTH-2:0], 1'b0};
    assign w_csa_sum   = r_sum ^ w_carry_sh ^ io_bus.in_data;
    assign w_csa_carry = (r_sum & w_carry_sh) | (r_sum & io_bus.in_data)
                       | (w_carry_sh & io_bus.in_data);
    assign w_terms     = (io_bus.n_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS)
                                                              : io_bus.n_terms;
    assign w_xfer      = r_in_ready & io_bus.in_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_carry     <= '0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_count <= w_terms;
                        r_busy  <= 1'b1;
                        if (w_terms != '0) begin
                            r_state    <= ST_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= ST_OUT;
                            r_out_sum   <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer) begin
                        r_sum   <= w_csa_sum;
                        r_carry <= w_csa_carry;
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_state    <= ST_RESOLVE;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_out_sum   <= r_sum + w_carry_sh;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_sum   = r_out_sum;
    assign io_bus.busy      = r_busy;
endmodule
